cs_result_tx: RTL and testbench

- Transmit end of the CS result path: accepts one CS result record (Y, avg, appr) per cycle on a valid-qualified parallel interface.
- Buffers records in a FIFO and serializes each as a fixed 5-byte frame on a byte-wide valid/ready stream toward the host or bus bridge.
- Drops and counts records on overflow; never stalls the CS datapath.

---
 rtl/cs_result_tx.sv | 137 +++++++++++++
 tb/tb_cs_result_tx.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cs_result_tx.sv
// Buffers CS result records and serializes each as a 5-byte frame; first byte is valid one cycle after the record lands in the FIFO.
// The sink stalls only the frame; a full FIFO drops new records and counts them, so the CS datapath never stalls.
module cs_result_tx #(
  parameter int         DEPTH = 8,
  parameter logic [7:0] SYNC  = 8'hA5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [9:0]               Y,
  input  logic [7:0]               avg,
  input  logic [7:0]               appr,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     tx_last,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {IDLE, SEND} state_t;

  logic [25:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [25:0]   shadow_q, shadow_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    drop_q, drop_d;
  logic          hs, frame_end, pop, push;

  // Record layout is {Y[9:0], avg[7:0], appr[7:0]}.
  function automatic logic [7:0] frame_byte(input logic [25:0] rec, input logic [2:0] i);
    case (i)
      3'd0:    frame_byte = SYNC;
      3'd1:    frame_byte = {6'b0, rec[25:24]};
      3'd2:    frame_byte = rec[23:16];
      3'd3:    frame_byte = rec[15:8];
      default: frame_byte = rec[7:0];
    endcase
  endfunction

  always_comb begin
    hs        = valid_q & tx_ready;
    frame_end = hs & (idx_q == 3'd4);
    pop       = (level_q != '0) & ((state_q == IDLE) | frame_end);
    // A full FIFO still accepts when the head leaves on the same edge.
    push      = in_valid & ((level_q != LW'(DEPTH)) | pop);

    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;

    if (pop) begin
      state_d  = SEND;
      idx_d    = 3'd0;
      shadow_d = mem_q[rd_ptr_q];
      data_d   = SYNC;
      valid_d  = 1'b1;
      last_d   = 1'b0;
    end else if (frame_end) begin
      state_d = IDLE;
      idx_d   = 3'd0;
      data_d  = 8'h00;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else if (hs) begin
      idx_d  = idx_q + 3'd1;
      data_d = frame_byte(shadow_q, idx_q + 3'd1);
      last_d = (idx_q == 3'd3);
    end

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);

    ovf_d  = ovf_q | (in_valid & ~push);
    drop_d = drop_q;
    if (in_valid && !push && drop_q != 8'hFF) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {Y, avg, appr};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= IDLE;
      idx_q    <= 3'd0;
      shadow_q <= '0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  assign tx_data  = data_q;
  assign tx_valid = valid_q;
  assign tx_last  = last_q;
  assign level    = level_q;
  assign overflow = ovf_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_cs_result_tx.sv
// Bench for cs_result_tx: directed scenarios plus randomized traffic against a queue-based reference.
module tb_cs_result_tx;
  localparam int         DEPTH = 8;
  localparam logic [7:0] SYNC  = 8'hA5;

  logic       clk = 1'b0;
  logic       reset, in_valid, tx_ready;
  logic [9:0] Y;
  logic [7:0] avg, appr;
  logic [7:0] tx_data;
  logic       tx_valid, tx_last;
  logic [3:0] level;
  logic       overflow;
  logic [7:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  // Reference: pending records, bytes of the frame being sent, and byte logs.
  logic [25:0] m_fifo[$];
  logic [7:0]  m_frame[$];
  logic [7:0]  m_sent[$];
  logic [7:0]  dut_sent[$];
  int          m_drops;
  bit          m_ovf;

  always #5 clk = ~clk;

  cs_result_tx #(.DEPTH(DEPTH), .SYNC(SYNC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .Y(Y), .avg(avg), .appr(appr),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  function automatic logic [7:0] frame_of(input logic [25:0] r, input int b);
    logic [9:0] y;
    y = r[25:16];
    case (b)
      0:       return SYNC;
      1:       return {6'b0, y[9:8]};
      2:       return y[7:0];
      3:       return r[15:8];
      default: return r[7:0];
    endcase
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_frame.delete();
    m_drops = 0;
    m_ovf   = 1'b0;
  endtask

  // Drives one cycle of inputs at the falling edge and advances the reference at the rising edge.
  task automatic step(input bit v, input logic [25:0] rec, input bit rdy);
    bit hs, pop, push;
    logic [25:0] r;
    logic [7:0]  b;
    in_valid = v;
    {Y, avg, appr} = rec;
    tx_ready = rdy;
    if (tx_valid && rdy) dut_sent.push_back(tx_data);
    @(posedge clk);
    hs   = (m_frame.size() > 0) && rdy;
    pop  = (m_fifo.size() > 0) && ((m_frame.size() == 0) || (hs && m_frame.size() == 1));
    push = v && ((m_fifo.size() < DEPTH) || pop);
    if (hs) begin
      b = m_frame.pop_front();
      m_sent.push_back(b);
    end
    if (pop) begin
      r = m_fifo.pop_front();
      for (int k = 0; k < 5; k++) m_frame.push_back(frame_of(r, k));
    end
    if (push) m_fifo.push_back(rec);
    if (v && !push) begin
      m_ovf = 1'b1;
      if (m_drops < 255) m_drops++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; tx_ready = 1'b0; Y = '0; avg = '0; appr = '0;
    #2 reset = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", tx_data); end
    checks++; if (tx_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", tx_last); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    logic [7:0] exp_b[5];
    exp_b = '{8'hA5, 8'h02, 8'hF3, 8'h54, 8'h50};
    step(1, {10'h2F3, 8'h54, 8'h50}, 1);
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL single_level1: got %0d want 1", level); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_early: got %b want 0", tx_valid); end
    for (int i = 0; i < 5; i++) begin
      step(0, '0, 1);
      checks++; if (tx_valid !== 1'b1 || tx_data !== exp_b[i]) begin
        errors++; $display("FAIL single_byte%0d: got v=%b %h want v=1 %h", i, tx_valid, tx_data, exp_b[i]);
      end
      checks++; if (tx_last !== (i == 4)) begin
        errors++; $display("FAIL single_last%0d: got %b want %b", i, tx_last, i == 4);
      end
    end
    step(0, '0, 1);
    checks++; if (tx_valid !== 1'b0 || level !== 4'd0) begin
      errors++; $display("FAIL single_end: got v=%b lvl=%0d want v=0 lvl=0", tx_valid, level);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b[10];
    logic [3:0] peak;
    exp_b = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h01, 8'hA5, 8'h03, 8'hFF, 8'hFF, 8'hFE};
    step(1, {10'h001, 8'h01, 8'h01}, 1);
    peak = level;
    step(1, {10'h3FF, 8'hFF, 8'hFE}, 1);
    if (level > peak) peak = level;
    for (int i = 0; i < 10; i++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== exp_b[i] || tx_last !== (i == 4 || i == 9)) begin
        errors++; $display("FAIL b2b_byte%0d: got v=%b %h l=%b want v=1 %h l=%b", i, tx_valid, tx_data, tx_last,
                           exp_b[i], (i == 4 || i == 9));
      end
      step(0, '0, 1);
      if (level > peak) peak = level;
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", tx_valid); end
    checks++; if (peak !== 4'd1) begin errors++; $display("FAIL b2b_peak: got %0d want 1", peak); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_b[5];
    exp_b = '{8'hA5, 8'h01, 8'hC7, 8'h3C, 8'h99};
    step(1, {10'h1C7, 8'h3C, 8'h99}, 1);
    repeat (3) step(0, '0, 1);
    checks++; if (tx_data !== 8'hC7) begin errors++; $display("FAIL bp_idx2: got %h want c7", tx_data); end
    for (int i = 0; i < 3; i++) begin
      step(0, '0, 0);
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hC7 || tx_last !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b %h l=%b want v=1 c7 l=0", i, tx_valid, tx_data, tx_last);
      end
    end
    for (int i = 3; i < 5; i++) begin
      step(0, '0, 1);
      checks++; if (tx_valid !== 1'b1 || tx_data !== exp_b[i] || tx_last !== (i == 4)) begin
        errors++; $display("FAIL bp_resume%0d: got v=%b %h l=%b want v=1 %h", i, tx_valid, tx_data, tx_last, exp_b[i]);
      end
    end
    step(0, '0, 1);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL bp_end: got %b want 0", tx_valid); end
  endtask

  task automatic test_overflow();
    logic [25:0] recs[12];
    for (int i = 0; i < 12; i++) recs[i] = 26'($urandom);
    for (int i = 0; i < 12; i++) step(1, recs[i], 0);
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL ovf_level: got %0d want 8", level); end
    checks++; if (drop_cnt !== 8'd3) begin errors++; $display("FAIL ovf_drop: got %0d want 3", drop_cnt); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    dut_sent.delete();
    repeat (50) step(0, '0, 1);
    checks++; if (dut_sent.size() !== 45) begin errors++; $display("FAIL ovf_count: got %0d want 45", dut_sent.size()); end
    for (int f = 0; f < 9; f++)
      for (int b = 0; b < 5; b++)
        if (f * 5 + b < dut_sent.size()) begin
          checks++; if (dut_sent[f*5+b] !== frame_of(recs[f], b)) begin
            errors++; $display("FAIL ovf_frame%0d_b%0d: got %h want %h", f, b, dut_sent[f*5+b], frame_of(recs[f], b));
          end
        end
    checks++; if (tx_valid !== 1'b0 || level !== 4'd0) begin
      errors++; $display("FAIL ovf_drain: got v=%b lvl=%0d want 0 0", tx_valid, level);
    end
  endtask

  task automatic test_full_push_pop();
    int saved;
    saved = m_drops;
    dut_sent.delete(); m_sent.delete();
    for (int i = 0; i < 9; i++) step(1, 26'($urandom), 0);
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL full_level: got %0d want 8", level); end
    repeat (4) step(0, '0, 1);
    checks++; if (tx_last !== 1'b1 || level !== 4'd8) begin
      errors++; $display("FAIL full_at_last: got l=%b lvl=%0d want 1 8", tx_last, level);
    end
    step(1, 26'($urandom), 1);
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL full_pushpop_level: got %0d want 8", level); end
    checks++; if (drop_cnt !== 8'(saved)) begin errors++; $display("FAIL full_pushpop_drop: got %0d want %0d", drop_cnt, saved); end
    checks++; if (tx_valid !== 1'b1 || tx_data !== SYNC) begin
      errors++; $display("FAIL full_next_frame: got v=%b %h want v=1 a5", tx_valid, tx_data);
    end
    repeat (55) step(0, '0, 1);
    checks++; if (dut_sent !== m_sent || dut_sent.size() != 50) begin
      errors++; $display("FAIL full_stream: got %0d bytes want 50 matching reference", dut_sent.size());
    end
  endtask

  task automatic test_random();
    bit v, rdy;
    dut_sent.delete(); m_sent.delete();
    for (int c = 0; c < 400; c++) begin
      v   = ($urandom_range(0, 99) < 35);
      rdy = ($urandom_range(0, 99) < 70);
      step(v, 26'($urandom), rdy);
      checks++; if (tx_valid !== (m_frame.size() > 0)) begin
        errors++; $display("FAIL rnd_valid@%0d: got %b want %b", c, tx_valid, m_frame.size() > 0);
      end
      checks++; if (level !== 4'(m_fifo.size())) begin
        errors++; $display("FAIL rnd_level@%0d: got %0d want %0d", c, level, m_fifo.size());
      end
      checks++; if (drop_cnt !== 8'(m_drops) || overflow !== m_ovf) begin
        errors++; $display("FAIL rnd_drop@%0d: got %0d/%b want %0d/%b", c, drop_cnt, overflow, m_drops, m_ovf);
      end
      if (m_frame.size() > 0) begin
        checks++; if (tx_data !== m_frame[0] || tx_last !== (m_frame.size() == 1)) begin
          errors++; $display("FAIL rnd_data@%0d: got %h l=%b want %h l=%b", c, tx_data, tx_last, m_frame[0], m_frame.size() == 1);
        end
      end
    end
    repeat (60) step(0, '0, 1);
    checks++; if (dut_sent !== m_sent) begin
      errors++; $display("FAIL rnd_stream: got %0d bytes want %0d", dut_sent.size(), m_sent.size());
    end
  endtask

  task automatic test_saturation();
    repeat (300) step(1, 26'($urandom), 0);
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_drop: got %0d want 255", drop_cnt); end
    checks++; if (drop_cnt !== 8'(m_drops)) begin errors++; $display("FAIL sat_model: got %0d want %0d", drop_cnt, m_drops); end
    repeat (60) step(0, '0, 1);
    checks++; if (tx_valid !== 1'b0 || level !== 4'd0) begin
      errors++; $display("FAIL sat_drain: got v=%b lvl=%0d want 0 0", tx_valid, level);
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 5; i++) step(1, 26'($urandom), 0);
    repeat (3) step(0, '0, 1);
    checks++; if (level !== 4'd4 || tx_valid !== 1'b1 || tx_data !== m_frame[0]) begin
      errors++; $display("FAIL mid_setup: got lvl=%0d v=%b %h want 4 1 %h", level, tx_valid, tx_data, m_frame[0]);
    end
    #2 reset = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0 || level !== 4'd0) begin
      errors++; $display("FAIL mid_async: got v=%b lvl=%0d want 0 0", tx_valid, level);
    end
    checks++; if (tx_last !== 1'b0 || tx_data !== 8'h00 || drop_cnt !== 8'd0) begin
      errors++; $display("FAIL mid_async_regs: got l=%b %h d=%0d want 0 00 0", tx_last, tx_data, drop_cnt);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(0, '0, 1);
      checks++; if (tx_valid !== 1'b0 || level !== 4'd0) begin
        errors++; $display("FAIL mid_after%0d: got v=%b lvl=%0d want 0 0", i, tx_valid, level);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_full_push_pop();
    test_random();
    test_saturation();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
